// File: rtl/multicycle_control.sv
// Multi-cycle main controller for the MIPS datapath.
// It walks each instruction through FETCH/DECODE/EXEC/MEM/WB and waits on the memory
// ready handshake, with a timeout. It decodes op/funct into datapath strobes and an ALU
// code, counts retired instructions, and parks in a sticky FAULT state when it sees an
// illegal instruction or a memory timeout.
module multicycle_control #(
    parameter int unsigned ALU_CTRL_W  = 4,
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [5:0]            op,
    input  logic [5:0]            funct,
    input  logic                  zero,
    input  logic                  mem_ready,
    output logic                  pc_write,
    output logic                  ir_write,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  regdst,
    output logic                  alu_src_imm,
    output logic                  wb_mem,
    output logic                  reg_write,
    output logic                  branch_taken,
    output logic [ALU_CTRL_W-1:0] alu_ctrl,
    output logic                  instr_done,
    output logic [CNT_W-1:0]      instr_count,
    output logic                  fault
);

    // The wait counter must be able to hold MEM_TIMEOUT-1.
    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_FAULT  = 3'd5
    } state_e;

    // Reset value of the class register is 0, i.e. C_RTYPE.
    typedef enum logic [1:0] {
        C_RTYPE = 2'd0,
        C_LW    = 2'd1,
        C_SW    = 2'd2,
        C_BEQ   = 2'd3
    } class_e;

    state_e            state_q, state_d;
    class_e            class_q;
    logic [3:0]        aluCode_q;
    logic [WAIT_W-1:0] waitCnt_q, waitCnt_d;
    logic [CNT_W-1:0]  instrCount_q;

    logic              decLegal;
    class_e            decClass;
    logic [3:0]        decAlu;
    logic              waitExpired;

    // Instruction decoder; its result only matters while DECODE latches it.
    always_comb begin
        decLegal = 1'b0;
        decClass = C_RTYPE;
        decAlu   = 4'b0000;
        case (op)
            6'b000000: begin
                decClass = C_RTYPE;
                decLegal = 1'b1;
                case (funct)
                    6'b100000: decAlu = 4'b0010;
                    6'b100010: decAlu = 4'b0110;
                    6'b100100: decAlu = 4'b0000;
                    6'b100101: decAlu = 4'b0001;
                    6'b101010: decAlu = 4'b0111;
                    default:   decLegal = 1'b0;
                endcase
            end
            6'b100011: begin
                decClass = C_LW;
                decAlu   = 4'b0010;
                decLegal = 1'b1;
            end
            6'b101011: begin
                decClass = C_SW;
                decAlu   = 4'b0010;
                decLegal = 1'b1;
            end
            6'b000100: begin
                decClass = C_BEQ;
                decAlu   = 4'b0110;
                decLegal = 1'b1;
            end
            default: decLegal = 1'b0;
        endcase
    end

    // The last allowed wait cycle passed without a ready; a ready in that cycle still wins.
    assign waitExpired = (waitCnt_q == WAIT_LAST) && !mem_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic for the instruction sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (waitExpired) begin
                    state_d = S_FAULT;
                end
            end
            S_DECODE: state_d = decLegal ? S_EXEC : S_FAULT;
            S_EXEC: begin
                case (class_q)
                    C_RTYPE: state_d = S_WB;
                    C_LW,
                    C_SW:    state_d = S_MEM;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    state_d = (class_q == C_LW) ? S_WB : S_FETCH;
                end else if (waitExpired) begin
                    state_d = S_FAULT;
                end
            end
            S_WB:    state_d = S_FETCH;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FETCH;
        endcase
    end

    // Class and ALU code are captured once in DECODE and held for the rest of the instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            class_q   <= C_RTYPE;
            aluCode_q <= 4'b0000;
        end else if (state_q == S_DECODE) begin
            class_q   <= decClass;
            aluCode_q <= decAlu;
        end
    end

    // Wait counter restarts on every state change and counts cycles spent without ready.
    always_comb begin
        waitCnt_d = waitCnt_q;
        if (state_d != state_q) begin
            waitCnt_d = '0;
        end else if (((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready) begin
            waitCnt_d = waitCnt_q + WAIT_W'(1);
        end
    end

    // Wait counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            waitCnt_q <= '0;
        end else begin
            waitCnt_q <= waitCnt_d;
        end
    end

    // Retired-instruction counter; wraps naturally at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            instrCount_q <= '0;
        end else if (instr_done) begin
            instrCount_q <= instrCount_q + CNT_W'(1);
        end
    end

    // Datapath strobes from state and latched class; only the handshake and beq zero are combinational.
    always_comb begin
        pc_write     = 1'b0;
        ir_write     = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        regdst       = 1'b0;
        alu_src_imm  = 1'b0;
        wb_mem       = 1'b0;
        reg_write    = 1'b0;
        branch_taken = 1'b0;
        alu_ctrl     = '0;
        instr_done   = 1'b0;
        fault        = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read = 1'b1;
                ir_write = mem_ready;
                pc_write = mem_ready;
            end
            S_EXEC: begin
                alu_ctrl[3:0] = aluCode_q;
                case (class_q)
                    C_RTYPE: regdst = 1'b1;
                    C_LW,
                    C_SW:    alu_src_imm = 1'b1;
                    default: begin
                        branch_taken = zero;
                        pc_write     = zero;
                        instr_done   = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                alu_src_imm = 1'b1;
                mem_read    = (class_q == C_LW);
                mem_write   = (class_q == C_SW);
                instr_done  = (class_q == C_SW) && mem_ready;
            end
            S_WB: begin
                reg_write  = 1'b1;
                wb_mem     = (class_q == C_LW);
                regdst     = (class_q == C_RTYPE);
                instr_done = 1'b1;
            end
            S_FAULT: fault = 1'b1;
            default: ;
        endcase
    end

    assign instr_count = instrCount_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control.
// Each instruction is expanded into its per-cycle expected strobe pattern, which is queued
// as the stimulus is driven and compared against the DUT on the falling edge.
module tb_multicycle_control;

    localparam int CNT_W = 4;

    localparam logic [14:0] PCW  = 15'h4000;
    localparam logic [14:0] IRW  = 15'h2000;
    localparam logic [14:0] MR   = 15'h1000;
    localparam logic [14:0] MW   = 15'h0800;
    localparam logic [14:0] RD   = 15'h0400;
    localparam logic [14:0] IMM  = 15'h0200;
    localparam logic [14:0] WBM  = 15'h0100;
    localparam logic [14:0] RW   = 15'h0080;
    localparam logic [14:0] BT   = 15'h0040;
    localparam logic [14:0] DONE = 15'h0002;
    localparam logic [14:0] FLT  = 15'h0001;
    localparam logic [14:0] NONE = 15'h0000;

    localparam logic [5:0] JUNK_OP = 6'b000010;
    localparam logic [5:0] JUNK_FN = 6'b111111;

    typedef enum {C_R, C_LW, C_SW, C_BEQ, C_ILL} cls_e;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        int         fetchWait;
        int         memWait;
        cls_e       cls;
        logic [3:0] alu;
    } vec_t;

    typedef struct {
        logic [14:0]      outs;
        logic [CNT_W-1:0] cnt;
        string            tag;
    } exp_t;

    logic             clk;
    logic             reset;
    logic [5:0]       op;
    logic [5:0]       funct;
    logic             zero;
    logic             mem_ready;
    logic             pc_write;
    logic             ir_write;
    logic             mem_read;
    logic             mem_write;
    logic             regdst;
    logic             alu_src_imm;
    logic             wb_mem;
    logic             reg_write;
    logic             branch_taken;
    logic [3:0]       alu_ctrl;
    logic             instr_done;
    logic [CNT_W-1:0] instr_count;
    logic             fault;

    exp_t             expQ[$];
    logic [CNT_W-1:0] expCount;
    int               compared;
    int               mismatched;
    vec_t             vecs[12];
    vec_t             hv;

    multicycle_control #(
        .ALU_CTRL_W (4),
        .MEM_TIMEOUT(16),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .op          (op),
        .funct       (funct),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .pc_write    (pc_write),
        .ir_write    (ir_write),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .regdst      (regdst),
        .alu_src_imm (alu_src_imm),
        .wb_mem      (wb_mem),
        .reg_write   (reg_write),
        .branch_taken(branch_taken),
        .alu_ctrl    (alu_ctrl),
        .instr_done  (instr_done),
        .instr_count (instr_count),
        .fault       (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value with its expectation and keep the tallies.
    task automatic checkOutput(input string what, input string tag, input logic [14:0] got,
                               input logic [14:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL %s (%s) at %0t: got %h, expected %h", what, tag, $time, got, want);
        end
    endtask

    // Drive one clock cycle of inputs and queue what the DUT must show during that cycle.
    task automatic applyStimulus(input logic [5:0] o, input logic [5:0] f, input logic z,
                                 input logic r, input logic rst, input logic [14:0] e,
                                 input string tag);
        exp_t x;
        op        = o;
        funct     = f;
        zero      = z;
        mem_ready = r;
        reset     = rst;
        x.outs = e;
        x.cnt  = expCount;
        x.tag  = tag;
        expQ.push_back(x);
        @(posedge clk);
        #1;
        reset = 1'b0;
        if (rst) begin
            expCount = '0;
        end else if ((e & DONE) != NONE) begin
            expCount = expCount + 1'b1;
        end
    endtask

    // Expand one instruction into its per-cycle expectations.
    task automatic runInstr(input vec_t v);
        logic [14:0] ex;
        logic [14:0] base;
        for (int i = 0; i < v.fetchWait; i++) begin
            applyStimulus(JUNK_OP, JUNK_FN, ~v.zero, 1'b0, 1'b0, MR, {v.name, " fetch wait"});
        end
        applyStimulus(JUNK_OP, JUNK_FN, ~v.zero, 1'b1, 1'b0, MR | IRW | PCW, {v.name, " fetch"});
        applyStimulus(v.op, v.funct, ~v.zero, 1'b1, 1'b0, NONE, {v.name, " decode"});
        if (v.cls == C_ILL) begin
            repeat (3) applyStimulus(JUNK_OP, JUNK_FN, 1'b1, 1'b1, 1'b0, FLT, {v.name, " fault"});
            return;
        end
        ex = {9'b0, v.alu, 2'b00};
        case (v.cls)
            C_R:     ex = ex | RD;
            C_LW,
            C_SW:    ex = ex | IMM;
            default: ex = ex | DONE | (v.zero ? (PCW | BT) : NONE);
        endcase
        applyStimulus(JUNK_OP, JUNK_FN, v.zero, 1'b1, 1'b0, ex, {v.name, " exec"});
        if (v.cls == C_LW || v.cls == C_SW) begin
            base = IMM | ((v.cls == C_LW) ? MR : MW);
            for (int i = 0; i < v.memWait; i++) begin
                applyStimulus(JUNK_OP, JUNK_FN, ~v.zero, 1'b0, 1'b0, base, {v.name, " mem wait"});
            end
            applyStimulus(JUNK_OP, JUNK_FN, ~v.zero, 1'b1, 1'b0,
                          base | ((v.cls == C_SW) ? DONE : NONE), {v.name, " mem"});
        end
        if (v.cls == C_R || v.cls == C_LW) begin
            applyStimulus(JUNK_OP, JUNK_FN, ~v.zero, 1'b0, 1'b0,
                          RW | DONE | ((v.cls == C_LW) ? WBM : NONE) | ((v.cls == C_R) ? RD : NONE),
                          {v.name, " wb"});
        end
    endtask

    // Scoreboard: every queued expectation is checked while its cycle is still in progress.
    always @(negedge clk) begin
        exp_t e;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("strobes", e.tag,
                        {pc_write, ir_write, mem_read, mem_write, regdst, alu_src_imm, wb_mem,
                         reg_write, branch_taken, alu_ctrl, instr_done, fault}, e.outs);
            checkOutput("instr_count", e.tag, 15'(instr_count), 15'(e.cnt));
        end
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    // Main stimulus sequence.
    initial begin
        compared   = 0;
        mismatched = 0;
        expCount   = '0;
        reset      = 1'b1;
        op         = JUNK_OP;
        funct      = JUNK_FN;
        zero       = 1'b0;
        mem_ready  = 1'b0;

        vecs[0]  = '{"add",        6'b000000, 6'b100000, 1'b0, 0,  0,  C_R,   4'b0010};
        vecs[1]  = '{"sub",        6'b000000, 6'b100010, 1'b0, 0,  0,  C_R,   4'b0110};
        vecs[2]  = '{"and",        6'b000000, 6'b100100, 1'b1, 0,  0,  C_R,   4'b0000};
        vecs[3]  = '{"or",         6'b000000, 6'b100101, 1'b0, 1,  0,  C_R,   4'b0001};
        vecs[4]  = '{"slt",        6'b000000, 6'b101010, 1'b0, 0,  0,  C_R,   4'b0111};
        vecs[5]  = '{"lw slow",    6'b100011, 6'b111111, 1'b0, 0,  3,  C_LW,  4'b0010};
        vecs[6]  = '{"sw",         6'b101011, 6'b000000, 1'b0, 0,  0,  C_SW,  4'b0010};
        vecs[7]  = '{"sw waits",   6'b101011, 6'b010101, 1'b1, 2,  1,  C_SW,  4'b0010};
        vecs[8]  = '{"beq taken",  6'b000100, 6'b000000, 1'b1, 0,  0,  C_BEQ, 4'b0110};
        vecs[9]  = '{"beq not",    6'b000100, 6'b000000, 1'b0, 0,  0,  C_BEQ, 4'b0110};
        vecs[10] = '{"lw fetch16", 6'b100011, 6'b000000, 1'b0, 15, 0,  C_LW,  4'b0010};
        vecs[11] = '{"lw mem16",   6'b100011, 6'b000000, 1'b1, 1,  15, C_LW,  4'b0010};

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            runInstr(vecs[i]);
        end

        $display("[TB] illegal opcode");
        hv = '{"illegal op", 6'b000010, 6'b100000, 1'b0, 0, 0, C_ILL, 4'b0000};
        runInstr(hv);
        applyStimulus(JUNK_OP, JUNK_FN, 1'b1, 1'b1, 1'b1, FLT, "fault during reset");
        runInstr(vecs[0]);

        $display("[TB] illegal R-type funct");
        hv = '{"illegal funct", 6'b000000, 6'b000000, 1'b0, 0, 0, C_ILL, 4'b0000};
        runInstr(hv);
        applyStimulus(JUNK_OP, JUNK_FN, 1'b0, 1'b0, 1'b1, FLT, "fault during reset");

        $display("[TB] fetch timeout");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(JUNK_OP, JUNK_FN, 1'b0, 1'b0, 1'b0, MR, "fetch timeout wait");
        end
        repeat (2) applyStimulus(6'b000000, 6'b100000, 1'b1, 1'b1, 1'b0, FLT, "fetch timeout fault");
        applyStimulus(JUNK_OP, JUNK_FN, 1'b0, 1'b1, 1'b1, FLT, "fault during reset");

        $display("[TB] mem timeout on sw");
        applyStimulus(JUNK_OP, JUNK_FN, 1'b0, 1'b1, 1'b0, MR | IRW | PCW, "sw to fetch");
        applyStimulus(6'b101011, 6'b000000, 1'b0, 1'b0, 1'b0, NONE, "sw to decode");
        applyStimulus(JUNK_OP, JUNK_FN, 1'b0, 1'b0, 1'b0, IMM | (15'(4'b0010) << 2), "sw to exec");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(JUNK_OP, JUNK_FN, 1'b0, 1'b0, 1'b0, MW | IMM, "sw to mem wait");
        end
        repeat (2) applyStimulus(JUNK_OP, JUNK_FN, 1'b0, 1'b1, 1'b0, FLT, "mem timeout fault");
        applyStimulus(JUNK_OP, JUNK_FN, 1'b0, 1'b0, 1'b1, FLT, "fault during reset");
        runInstr(vecs[6]);

        $display("[TB] reset in MEM of sw");
        applyStimulus(JUNK_OP, JUNK_FN, 1'b0, 1'b1, 1'b0, MR | IRW | PCW, "sw rst fetch");
        applyStimulus(6'b101011, 6'b000000, 1'b0, 1'b0, 1'b0, NONE, "sw rst decode");
        applyStimulus(JUNK_OP, JUNK_FN, 1'b0, 1'b0, 1'b0, IMM | (15'(4'b0010) << 2), "sw rst exec");
        applyStimulus(JUNK_OP, JUNK_FN, 1'b0, 1'b0, 1'b0, MW | IMM, "sw rst mem wait");
        applyStimulus(JUNK_OP, JUNK_FN, 1'b0, 1'b0, 1'b1, MW | IMM, "sw rst mem in reset");
        applyStimulus(JUNK_OP, JUNK_FN, 1'b0, 1'b0, 1'b0, MR, "fetch after reset");
        runInstr(vecs[4]);

        $display("[TB] counter wrap with 17 retires");
        applyStimulus(JUNK_OP, JUNK_FN, 1'b0, 1'b0, 1'b1, MR, "reset before wrap");
        for (int i = 0; i < 17; i++) begin
            runInstr(vecs[8 + (i % 2)]);
        end
        applyStimulus(JUNK_OP, JUNK_FN, 1'b0, 1'b0, 1'b0, MR, "count after 17 retires");

        @(negedge clk);
        #1;
        compared++;
        if (expQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL scoreboard drain: got %0d pending, expected 0", expQ.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
